// File: rtl/pc_fetch_gen_pkg.sv
// riscv_fetch_pkg: shared fetch-side constants for the PC generator.
// State encoding, datapath width and default boot address.
package riscv_fetch_pkg;

   localparam int X_LEN = 32;

   typedef logic [2:0] state_t;

   localparam state_t S_BOOT      = 3'd0;
   localparam state_t S_RUN       = 3'd1;
   localparam state_t S_REDIRECT  = 3'd2;
   localparam state_t S_HALT_WAIT = 3'd3;
   localparam state_t S_HALTED    = 3'd4;

   localparam logic [31:0] NOP = 32'h0000_0013;

   localparam logic [X_LEN-1:0] DEFAULT_RESET_PC = '0;

   function automatic logic misaligned(input logic [1:0] lo);
      return |lo;
   endfunction

endpackage

// File: rtl/pc_fetch_gen_if.sv
// pc_fetch_gen_if: request/abort bus between PC generator and fetch unit.
// master = PC generator side, slave = fetch unit side.
interface pc_fetch_gen_if #(
   parameter int X_LEN = riscv_fetch_pkg::X_LEN
);

   logic [X_LEN-1:0] pc_o;
   logic             pc_valid_o;
   logic             abort_rvalid_o;
   logic             stop_request_o;
   logic             stall_if_i;
   logic             stall_id_i;
   logic             reset_able_i;

   modport master (
      output pc_o,
      output pc_valid_o,
      output abort_rvalid_o,
      output stop_request_o,
      input  stall_if_i,
      input  stall_id_i,
      input  reset_able_i
   );

   modport slave (
      input  pc_o,
      input  pc_valid_o,
      input  abort_rvalid_o,
      input  stop_request_o,
      output stall_if_i,
      output stall_id_i,
      output reset_able_i
   );

endinterface

// File: rtl/pc_fetch_gen.sv
// pc_fetch_gen: fetch PC generator with redirect, stall and halt handling.
// Optional misaligned-target trap enabled by PCGEN_MISALIGN_TRAP_EN.
module pc_fetch_gen #(
   parameter int               X_LEN    = riscv_fetch_pkg::X_LEN,
   parameter logic [X_LEN-1:0] RESET_PC = riscv_fetch_pkg::DEFAULT_RESET_PC
) (
   input  logic             clk,
   input  logic             reset,
   pc_fetch_gen_if.master   fetch,
   input  logic             stall_exec_i,
   input  logic             branch_i,
   input  logic [X_LEN-1:0] branch_target_i,
   input  logic             halt_i,
   output logic [X_LEN-1:0] pc_inflight_o,
   output logic [X_LEN-1:0] pc_id_o,
   output logic [X_LEN-1:0] fetch_count_o,
`ifdef PCGEN_MISALIGN_TRAP_EN
   output logic             misalign_trap_o,
   output logic [X_LEN-1:0] mtval_o,
`endif
   output logic             halted_o
);

   import riscv_fetch_pkg::*;

   state_t           state_q;
   state_t           state_d;
   logic [X_LEN-1:0] pc_q;
   logic [X_LEN-1:0] pc_d;
   logic [X_LEN-1:0] inflight_q;
   logic [X_LEN-1:0] id_q;
   logic [X_LEN-1:0] count_q;
   logic             valid;
   logic             stop;
   logic             halted;
   logic             run_like;
   logic             accept;
   logic             redirect;
   logic             id_adv;
`ifdef PCGEN_MISALIGN_TRAP_EN
   logic             trap;
   logic             trap_q;
   logic [X_LEN-1:0] mtval_q;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_BOOT;
      end else begin
         state_q <= state_d;
      end
   end

   // Once halting, nothing but reset leaves the halt states.
   always_comb begin
      state_d  = state_q;
      redirect = 1'b0;
`ifdef PCGEN_MISALIGN_TRAP_EN
      trap     = 1'b0;
`endif
      unique case (state_q)
         S_HALT_WAIT: begin
            if (fetch.reset_able_i) begin
               state_d = S_HALTED;
            end
         end
         S_HALTED: begin
            state_d = S_HALTED;
         end
         default: begin
            if (halt_i) begin
               state_d = S_HALT_WAIT;
`ifdef PCGEN_MISALIGN_TRAP_EN
            end else if (branch_i &&
                         misaligned(branch_target_i[1:0])) begin
               state_d = S_HALT_WAIT;
               trap    = 1'b1;
`endif
            end else if (branch_i) begin
               state_d  = S_REDIRECT;
               redirect = 1'b1;
            end else begin
               state_d = S_RUN;
            end
         end
      endcase
   end

   always_comb begin
      valid    = 1'b0;
      stop     = 1'b0;
      halted   = 1'b0;
      run_like = 1'b0;
      unique case (1'b1)
         (state_q == S_RUN): begin
            valid    = 1'b1;
            run_like = 1'b1;
         end
         (state_q == S_REDIRECT): begin
            run_like = 1'b1;
         end
         (state_q == S_HALT_WAIT): begin
            stop = 1'b1;
         end
         (state_q == S_HALTED): begin
            stop   = 1'b1;
            halted = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign accept = valid & ~fetch.stall_if_i & ~stall_exec_i
                 & ~branch_i & ~halt_i & ~stop;

   assign id_adv = ~fetch.stall_id_i & ~stall_exec_i
                 & ~fetch.stall_if_i & ~branch_i;

   always_comb begin
      pc_d = pc_q;
      if (redirect) begin
         pc_d = {branch_target_i[X_LEN-1:2], 2'b00};
      end else if (accept) begin
         pc_d = pc_q + X_LEN'(4);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         inflight_q <= '0;
         id_q       <= '0;
         count_q    <= '0;
      end else begin
         pc_q <= pc_d;
         if (accept) begin
            inflight_q <= pc_q;
            count_q    <= count_q + X_LEN'(1);
         end
         if (id_adv) begin
            id_q <= inflight_q;
         end
      end
   end

`ifdef PCGEN_MISALIGN_TRAP_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         trap_q  <= 1'b0;
         mtval_q <= '0;
      end else if (trap) begin
         trap_q  <= 1'b1;
         mtval_q <= branch_target_i;
      end
   end

   assign misalign_trap_o = trap_q;
   assign mtval_o         = mtval_q;
`endif

   assign fetch.pc_o           = pc_q;
   assign fetch.pc_valid_o     = valid;
   assign fetch.stop_request_o = stop;
   assign fetch.abort_rvalid_o = branch_i & run_like;
   assign pc_inflight_o        = inflight_q;
   assign pc_id_o              = id_q;
   assign fetch_count_o        = count_q;
   assign halted_o             = halted;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// tb_pc_fetch_gen: directed table, corner sequences and random run
// checked against a cycle-level reference model of the PC generator.
module tb_pc_fetch_gen;

   localparam logic [31:0] RPC = 32'h0000_0100;

   localparam int MB = 0;
   localparam int MR = 1;
   localparam int MD = 2;
   localparam int MW = 3;
   localparam int MH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_exec;
   logic        branch;
   logic [31:0] target;
   logic        halt;
   logic [31:0] pc_inflight;
   logic [31:0] pc_id;
   logic [31:0] fcount;
   logic        halted;
`ifdef PCGEN_MISALIGN_TRAP_EN
   logic        trap_o;
   logic [31:0] mtval_o;
`endif

   pc_fetch_gen_if bus ();

   always #5 clk = ~clk;

   pc_fetch_gen #(
      .X_LEN    (32),
      .RESET_PC (RPC)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .fetch           (bus),
      .stall_exec_i    (stall_exec),
      .branch_i        (branch),
      .branch_target_i (target),
      .halt_i          (halt),
      .pc_inflight_o   (pc_inflight),
      .pc_id_o         (pc_id),
      .fetch_count_o   (fcount),
`ifdef PCGEN_MISALIGN_TRAP_EN
      .misalign_trap_o (trap_o),
      .mtval_o         (mtval_o),
`endif
      .halted_o        (halted)
   );

   int checks = 0;
   int errors = 0;

   int          m_mode;
   logic [31:0] m_pc, m_inf, m_id, m_cnt, m_mtval;
   bit          m_trap;
   bit          mvalid = 1'b0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic check_model();
      bit rl;
      if (!mvalid) return;
      rl = (m_mode == MR) || (m_mode == MD);
      chk("m_pc", bus.pc_o, m_pc);
      chk("m_valid", 32'(bus.pc_valid_o), 32'(m_mode == MR));
      chk("m_abort", 32'(bus.abort_rvalid_o), 32'(branch & rl));
      chk("m_stop", 32'(bus.stop_request_o), 32'(m_mode >= MW));
      chk("m_halted", 32'(halted), 32'(m_mode == MH));
      chk("m_inflight", pc_inflight, m_inf);
      chk("m_id", pc_id, m_id);
      chk("m_count", fcount, m_cnt);
`ifdef PCGEN_MISALIGN_TRAP_EN
      chk("m_trap", 32'(trap_o), 32'(m_trap));
      chk("m_mtval", mtval_o, m_mtval);
`endif
   endtask

   // Next-cycle model from the architectural rules.
   task automatic model_step();
      int          nmode;
      logic [31:0] npc, ninf, nid, ncnt;
      bit          acc, bad;
      if (reset) begin
         m_mode = MB; m_pc = RPC; m_inf = 0; m_id = 0; m_cnt = 0;
         m_trap = 0; m_mtval = 0; mvalid = 1'b1;
         return;
      end
      nmode = m_mode; npc = m_pc; ninf = m_inf; nid = m_id; ncnt = m_cnt;
      acc = (m_mode == MR) && !bus.stall_if_i && !stall_exec
            && !branch && !halt;
`ifdef PCGEN_MISALIGN_TRAP_EN
      bad = (target % 4) != 0;
`else
      bad = 1'b0;
`endif
      if (m_mode == MW) begin
         if (bus.reset_able_i) nmode = MH;
      end else if (m_mode == MH) begin
         nmode = MH;
      end else if (halt) begin
         nmode = MW;
      end else if (branch && bad) begin
         nmode = MW; m_trap = 1'b1; m_mtval = target;
      end else if (branch) begin
         nmode = MD; npc = target - (target % 4);
      end else begin
         nmode = MR;
      end
      if (acc) begin
         ninf = m_pc; npc = m_pc + 4; ncnt = m_cnt + 1;
      end
      if (!bus.stall_id_i && !stall_exec && !bus.stall_if_i && !branch)
         nid = m_inf;
      m_mode = nmode; m_pc = npc; m_inf = ninf; m_id = nid; m_cnt = ncnt;
   endtask

   task automatic tick();
      check_model();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic drive(bit sif, bit br, logic [31:0] tg, bit hl,
                        bit rab, bit rst);
      bus.stall_if_i   = sif;
      bus.stall_id_i   = 1'b0;
      bus.reset_able_i = rab;
      stall_exec       = 1'b0;
      branch           = br;
      target           = tg;
      halt             = hl;
      reset            = rst;
   endtask

   typedef struct {
      bit          sif, br, hl, rab, rst;
      logic [31:0] tg;
      logic [31:0] e_pc;
      bit          e_v, e_a, e_s, e_h;
      logic [31:0] e_cnt;
   } row_t;

   function automatic row_t mk(bit sif, bit br, bit hl, bit rab, bit rst,
                               logic [31:0] tg, logic [31:0] e_pc,
                               bit e_v, bit e_a, bit e_s, bit e_h,
                               logic [31:0] e_cnt);
      row_t r;
      r.sif = sif; r.br = br; r.hl = hl; r.rab = rab; r.rst = rst;
      r.tg = tg; r.e_pc = e_pc; r.e_v = e_v; r.e_a = e_a;
      r.e_s = e_s; r.e_h = e_h; r.e_cnt = e_cnt;
      return r;
   endfunction

   row_t tbl[23];

   initial begin
      logic [31:0] tg;
      tbl[0]  = mk(0,0,0,0,0, 0,        32'h100,  0,0,0,0, 0);
      tbl[1]  = mk(0,0,0,0,0, 0,        32'h100,  1,0,0,0, 0);
      tbl[2]  = mk(0,0,0,0,0, 0,        32'h104,  1,0,0,0, 1);
      tbl[3]  = mk(1,0,0,0,0, 0,        32'h108,  1,0,0,0, 2);
      tbl[4]  = mk(1,0,0,0,0, 0,        32'h108,  1,0,0,0, 2);
      tbl[5]  = mk(1,0,0,0,0, 0,        32'h108,  1,0,0,0, 2);
      tbl[6]  = mk(0,0,0,0,0, 0,        32'h108,  1,0,0,0, 2);
      tbl[7]  = mk(0,0,0,0,0, 0,        32'h10C,  1,0,0,0, 3);
      tbl[8]  = mk(1,1,0,0,0, 32'h2000, 32'h110,  1,1,0,0, 4);
      tbl[9]  = mk(0,0,0,0,0, 0,        32'h2000, 0,0,0,0, 4);
      tbl[10] = mk(0,0,0,0,0, 0,        32'h2000, 1,0,0,0, 4);
      tbl[11] = mk(0,1,0,0,0, 32'h2002, 32'h2004, 1,1,0,0, 5);
`ifdef PCGEN_MISALIGN_TRAP_EN
      tbl[12] = mk(0,0,0,0,1, 0,        32'h2004, 0,0,1,0, 5);
`else
      tbl[12] = mk(0,0,0,0,1, 0,        32'h2000, 0,0,0,0, 5);
`endif
      tbl[13] = mk(0,0,0,0,0, 0,        32'h100,  0,0,0,0, 0);
      tbl[14] = mk(0,0,0,0,0, 0,        32'h100,  1,0,0,0, 0);
      tbl[15] = mk(0,0,1,0,0, 0,        32'h104,  1,0,0,0, 1);
      tbl[16] = mk(0,0,0,0,0, 0,        32'h104,  0,0,1,0, 1);
      tbl[17] = mk(0,0,0,0,0, 0,        32'h104,  0,0,1,0, 1);
      tbl[18] = mk(0,0,0,0,0, 0,        32'h104,  0,0,1,0, 1);
      tbl[19] = mk(0,0,0,0,0, 0,        32'h104,  0,0,1,0, 1);
      tbl[20] = mk(0,0,0,1,0, 0,        32'h104,  0,0,1,0, 1);
      tbl[21] = mk(0,1,0,0,0, 32'h3000, 32'h104,  0,0,1,1, 1);
      tbl[22] = mk(0,0,0,0,0, 0,        32'h104,  0,0,1,1, 1);

      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      #2; tick();
      #2; tick();

      for (int i = 0; i < 23; i++) begin
         drive(tbl[i].sif, tbl[i].br, tbl[i].tg, tbl[i].hl,
               tbl[i].rab, tbl[i].rst);
         #2;
         chk($sformatf("t%0d_pc", i), bus.pc_o, tbl[i].e_pc);
         chk($sformatf("t%0d_valid", i), 32'(bus.pc_valid_o), 32'(tbl[i].e_v));
         chk($sformatf("t%0d_abort", i), 32'(bus.abort_rvalid_o),
             32'(tbl[i].e_a));
         chk($sformatf("t%0d_stop", i), 32'(bus.stop_request_o),
             32'(tbl[i].e_s));
         chk($sformatf("t%0d_halted", i), 32'(halted), 32'(tbl[i].e_h));
         chk($sformatf("t%0d_count", i), fcount, tbl[i].e_cnt);
`ifdef PCGEN_MISALIGN_TRAP_EN
         if (i == 12) begin
            chk("trap_set", 32'(trap_o), 32'd1);
            chk("trap_mtval", mtval_o, 32'h2002);
         end
`endif
         tick();
      end

      // Wrap at the top of the address space, then a redirect chain.
      drive(0, 0, 0, 0, 0, 1); #2; tick();
      drive(0, 0, 0, 0, 0, 0); #2; tick();
      #2; tick();
      drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0); #2; tick();
      drive(0, 0, 0, 0, 0, 0); #2; tick();
      #2;
      chk("wrap_pre", bus.pc_o, 32'hFFFF_FFFC);
      chk("wrap_pre_v", 32'(bus.pc_valid_o), 32'd1);
      tick();
      #2;
      chk("wrap_pc", bus.pc_o, 32'h0);
      chk("wrap_inflight", pc_inflight, 32'hFFFF_FFFC);
      tick();
      drive(0, 1, 32'h4000, 0, 0, 0); #2; tick();
      drive(0, 1, 32'h5000, 0, 0, 0); #2;
      chk("redir_abort", 32'(bus.abort_rvalid_o), 32'd1);
      tick();
      drive(0, 0, 0, 0, 0, 0); #2;
      chk("redir_newer", bus.pc_o, 32'h5000);
      chk("redir_v", 32'(bus.pc_valid_o), 32'd0);
      tick();
      drive(0, 1, 32'h6000, 0, 0, 0); #2; tick();
      drive(0, 0, 0, 0, 0, 1); #2; tick();
      drive(0, 0, 0, 0, 0, 0); #2;
      chk("rst_pc", bus.pc_o, RPC);
      chk("rst_v", 32'(bus.pc_valid_o), 32'd0);
      chk("rst_abort", 32'(bus.abort_rvalid_o), 32'd0);
      chk("rst_cnt", fcount, 32'd0);
      tick();

      for (int c = 0; c < 800; c++) begin
         bus.stall_if_i   = ($urandom_range(0, 3) == 0);
         bus.stall_id_i   = ($urandom_range(0, 3) == 0);
         bus.reset_able_i = ($urandom_range(0, 1) == 0);
         stall_exec       = ($urandom_range(0, 6) == 0);
         branch           = ($urandom_range(0, 9) == 0);
         tg = $urandom;
`ifdef PCGEN_MISALIGN_TRAP_EN
         if ($urandom_range(0, 7) != 0) tg = tg & 32'hFFFF_FFFC;
`endif
         target = tg;
         halt   = 1'b0;
         reset  = ($urandom_range(0, 39) == 0);
         #2;
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
